// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store data RAM.
//   - funct3 encodings for loads and stores
//   - controller state enum (CLEAR, RUN)
//   - fault-cause codes, to be shared with the trap unit
//   - small decode helpers for legality and alignment
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } lsu_state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_ILLEGAL  = 2'd2;
    localparam logic [1:0] FC_RANGE    = 2'd3;

    // Stores only have B/H/W; the unsigned variants exist for loads only.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load alignment and extension.
//   word_i   raw 32-bit word read from the array
//   off_i    byte offset addr[1:0]
//   funct3_i load funct3 (LB/LH/LW/LBU/LHU)
//   rdata_o  right-aligned, sign- or zero-extended result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Little-endian lane selection followed by extension per funct3.
    always_comb begin
        byte_s  = word_i[8*off_i +: 8];
        half_s  = off_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_o = 32'd0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata_o = {{16{half_s[15]}}, half_s};
            F3_W:    rdata_o = word_i;
            F3_BU:   rdata_o = {24'd0, byte_s};
            F3_HU:   rdata_o = {16'd0, half_s};
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: byte-addressable data RAM for the load/store unit.
//   clk, reset_n        clock and async active-low reset
//   req_valid/req_ready request handshake (ready low while clearing)
//   req_write           1 = store, 0 = load
//   req_funct3          RISC-V access size / sign
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle response pulse, two edges after acceptance
//   rsp_rdata           extended load data, 0 for stores and faults
//   rsp_fault           misaligned, illegal or out-of-range access
//   busy                post-reset zero-fill in progress
module lsu_data_ram
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS    = 256,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam lsu_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    logic [31:0]      mem_q [DEPTH_WORDS];

    lsu_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    // Acceptance-stage registers: raw word plus what alignment needs.
    logic             acc_valid_q, acc_fault_q, acc_load_q;
    logic [31:0]      acc_word_q;
    logic [1:0]       acc_off_q;
    logic [2:0]       acc_f3_q;

    logic             rsp_valid_q, rsp_fault_q;
    logic [31:0]      rsp_rdata_q;

    logic             accept_s;
    logic [IDX_W-1:0] idx_s;
    logic [1:0]       off_s;
    logic [1:0]       cause_s;
    logic             out_of_range_s;
    logic [3:0]       be_s;
    logic [31:0]      wr_data_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [31:0]      aligned_s;

    assign req_ready      = (state_q == RUN);
    assign busy           = (state_q == CLEAR);
    assign accept_s       = req_valid && req_ready;
    assign idx_s          = req_addr[IDX_W+1:2];
    assign off_s          = req_addr[1:0];
    assign out_of_range_s = |req_addr[ADDR_W-1:IDX_W+2];

    // Fault classification; illegal encoding takes priority over range and alignment.
    always_comb begin
        cause_s = FC_NONE;
        if (!f3_legal(req_write, req_funct3)) begin
            cause_s = FC_ILLEGAL;
        end else if (out_of_range_s) begin
            cause_s = FC_RANGE;
        end else if (f3_misaligned(req_funct3, off_s)) begin
            cause_s = FC_MISALIGN;
        end else begin
            cause_s = FC_NONE;
        end
    end

    // Array write port: zero-fill while clearing, else lane-enabled stores.
    always_comb begin
        be_s      = 4'b0000;
        wr_data_s = 32'd0;
        wr_idx_s  = idx_s;
        if (state_q == CLEAR) begin
            be_s     = 4'b1111;
            wr_idx_s = clr_idx_q;
        end else if (accept_s && req_write && (cause_s == FC_NONE)) begin
            case (req_funct3)
                F3_B: begin
                    be_s      = 4'b0001 << off_s;
                    wr_data_s = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    be_s      = off_s[1] ? 4'b1100 : 4'b0011;
                    wr_data_s = {2{req_wdata[15:0]}};
                end
                F3_W: begin
                    be_s      = 4'b1111;
                    wr_data_s = req_wdata;
                end
                default: begin
                    be_s      = 4'b0000;
                    wr_data_s = 32'd0;
                end
            endcase
        end else begin
            be_s = 4'b0000;
        end
    end

    // Storage array; contents are not reset, the clear sequence zeroes them.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
                mem_q[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
        end
    end

    // Controller next state: walk clr_idx through the array, then run.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    state_d = CLEAR;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_STATE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Acceptance stage: synchronous array read and fault capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_valid_q <= 1'b0;
            acc_fault_q <= 1'b0;
            acc_load_q  <= 1'b0;
            acc_word_q  <= 32'd0;
            acc_off_q   <= 2'b00;
            acc_f3_q    <= 3'b000;
        end else begin
            acc_valid_q <= accept_s;
            acc_fault_q <= accept_s && (cause_s != FC_NONE);
            acc_load_q  <= accept_s && !req_write && (cause_s == FC_NONE);
            if (accept_s) begin
                acc_word_q <= mem_q[idx_s];
                acc_off_q  <= off_s;
                acc_f3_q   <= req_funct3;
            end
        end
    end

    lsu_load_align u_align (
        .word_i   (acc_word_q),
        .off_i    (acc_off_q),
        .funct3_i (acc_f3_q),
        .rdata_o  (aligned_s)
    );

    // Response register: data only for successful loads, zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= acc_valid_q;
            rsp_fault_q <= acc_fault_q;
            rsp_rdata_q <= acc_load_q ? aligned_s : 32'd0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
